// File: rtl/row_tile_feeder_pkg.sv
// ============================================================================
// feeder_pkg
// Shared types and helpers for the row tile feeder.
//   feeder_state_e : sequencing states of the feeder FSM
//   clog2_min1     : address/select width that never collapses to zero bits
//   base_addr      : buffer address of element 0 of (tile, channel)
// ============================================================================
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tiles are laid out back to back; inside a tile each channel owns a
    // contiguous run of k_depth elements.
    function automatic int unsigned base_addr(input int unsigned tile,
                                              input int unsigned ch,
                                              input int unsigned k_depth,
                                              input int unsigned n_ch);
        return tile * n_ch * k_depth + ch * k_depth;
    endfunction

endpackage

// File: rtl/row_tile_feeder_if.sv
// ============================================================================
// row_tile_feeder_if
// Bundles the host write port, stream control and array-side signals of the
// row tile feeder.
//   master : host/DMA and array side (drives write port, start/flush, tile
//            select and passthrough_valid_i; observes everything else)
//   slave  : the feeder itself
// Signals: wr_en_i, wr_addr_i, wr_data_i, wr_err_o, start_i, tile_sel_i,
//          flush_i, passthrough_valid_i, data_o, data_valid_o, last_o,
//          busy_o, done_o, queue_empty_o
// ============================================================================
interface row_tile_feeder_if
    import feeder_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int K_DEPTH    = 8,
    parameter int TILES      = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int AW = clog2_min1(N_CH * K_DEPTH * TILES);
    localparam int TW = clog2_min1(TILES);

    logic                                 wr_en_i;
    logic [AW-1:0]                        wr_addr_i;
    logic [DATA_WIDTH-1:0]                wr_data_i;
    logic                                 wr_err_o;
    logic                                 start_i;
    logic [TW-1:0]                        tile_sel_i;
    logic                                 flush_i;
    logic [N_CH-1:0]                      passthrough_valid_i;
    logic [N_CH-1:0][DATA_WIDTH-1:0]      data_o;
    logic                                 data_valid_o;
    logic [N_CH-1:0]                      last_o;
    logic                                 busy_o;
    logic                                 done_o;
    logic                                 queue_empty_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, start_i, tile_sel_i, flush_i,
               passthrough_valid_i,
        input  wr_err_o, data_o, data_valid_o, last_o, busy_o, done_o,
               queue_empty_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, start_i, tile_sel_i, flush_i,
               passthrough_valid_i,
        output wr_err_o, data_o, data_valid_o, last_o, busy_o, done_o,
               queue_empty_o
    );

endinterface

// File: rtl/row_tile_feeder_channel_ctrl.sv
// ============================================================================
// feeder_channel_ctrl
// Per-channel sequencing for one row of the feeder: passthrough delay line,
// read pointer, element count, exhausted flag and last pulse.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   flush_i        return pointer/count to reset values, clear delay line
//   load_i         accepted start: load base_i, clear count
//   base_i         first buffer address of this channel in the chosen tile
//   prime_i        feeder in PRIME: first element becomes current
//   stream_i       feeder in STREAM: delayed pulses may advance
//   pt_i           passthrough_valid from the edge PE of this row
//   addr_o         current read pointer
//   adv_o          pointer advances at the coming edge
//   exhausted_o    all K_DEPTH elements have been presented
//   last_o         one-cycle pulse after the count reaches K_DEPTH
// ============================================================================
module feeder_channel_ctrl #(
    parameter int            K_DEPTH    = 8,
    parameter int            PT_DELAY   = 2,
    parameter int            AW         = 6,
    parameter logic [AW-1:0] RESET_BASE = '0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic          prime_i,
    input  logic          stream_i,
    input  logic          pt_i,
    output logic [AW-1:0] addr_o,
    output logic          adv_o,
    output logic          exhausted_o,
    output logic          last_o
);

    localparam int CW = $clog2(K_DEPTH + 1);

    logic [PT_DELAY-1:0] sh_q;
    logic [AW-1:0]       addr_q;
    logic [CW-1:0]       cnt_q;
    logic                last_q;
    logic                pt_d;

    assign pt_d        = sh_q[PT_DELAY-1];
    assign exhausted_o = (cnt_q == CW'(K_DEPTH));
    // Pulses reaching an exhausted channel are dropped so the pointer
    // never leaves this channel's run in the buffer.
    assign adv_o       = stream_i && pt_d && !exhausted_o;
    assign addr_o      = addr_q;
    assign last_o      = last_q;

    // The delay line shifts in every state; only the consumer of pt_d
    // (adv_o) is gated to STREAM.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_q   <= '0;
            addr_q <= RESET_BASE;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (flush_i) begin
            sh_q   <= '0;
            addr_q <= RESET_BASE;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            sh_q   <= (sh_q << 1) | PT_DELAY'(pt_i);
            last_q <= 1'b0;
            if (load_i) begin
                addr_q <= base_i;
                cnt_q  <= '0;
            end else if (prime_i) begin
                cnt_q  <= CW'(1);
                last_q <= (K_DEPTH == 1);
            end else if (adv_o) begin
                addr_q <= addr_q + AW'(1);
                cnt_q  <= cnt_q + CW'(1);
                last_q <= (cnt_q == CW'(K_DEPTH - 1));
            end
        end
    end

endmodule

// File: rtl/row_tile_feeder.sv
// ============================================================================
// row_tile_feeder
// Multi-tile operand buffer feeding the west edge of the systolic array.
// The host loads N_CH*K_DEPTH*TILES elements through the write port while
// idle, then streams any resident tile; each row channel advances on its
// edge PE's passthrough_valid delayed by PT_DELAY cycles.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   bus (slave)    write port (wr_en_i/wr_addr_i/wr_data_i/wr_err_o),
//                  control (start_i/tile_sel_i/flush_i),
//                  array side (passthrough_valid_i/data_o/data_valid_o/
//                  last_o), status (busy_o/done_o/queue_empty_o)
// Build option:
//   FEEDER_ZERO_PAD_EN  drive zero on a channel once it is exhausted or
//                       while idle, instead of holding the buffer word.
// ============================================================================
module row_tile_feeder
    import feeder_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int K_DEPTH    = 8,
    parameter int TILES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PT_DELAY   = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    row_tile_feeder_if.slave bus
);

    localparam int DEPTH = N_CH * K_DEPTH * TILES;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int TW    = clog2_min1(TILES);

    // One extra bit keeps the range checks from being trivially true when
    // DEPTH or TILES is a power of two.
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [TW:0] TILES_W = TILES[TW:0];

    feeder_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]         mem [DEPTH];
    logic [N_CH-1:0][AW-1:0]       addr;
    logic [N_CH-1:0][AW-1:0]       base;
    logic [N_CH-1:0]               adv;
    logic [N_CH-1:0]               exhausted;
    logic                          is_idle;
    logic                          addr_ok;
    logic                          sel_ok;
    logic                          wr_accept;
    logic                          start_accept;
    logic                          dv_q;
    logic                          err_q;

    assign is_idle      = (state_q == IDLE);
    assign addr_ok      = ({1'b0, bus.wr_addr_i} < DEPTH_W);
    assign sel_ok       = ({1'b0, bus.tile_sel_i} < TILES_W);
    assign wr_accept    = bus.wr_en_i && is_idle && addr_ok && !bus.flush_i;
    assign start_accept = bus.start_i && is_idle && sel_ok && !bus.flush_i;

    // Operand buffer: written only while idle, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    // State register plus the registered data_valid and write-error pulses.
    // data_valid follows channel 0: once for the PRIME element, then once
    // per channel-0 advance.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= (state_q == PRIME) || adv[0];
            err_q   <= (bus.wr_en_i && !wr_accept) ||
                       (bus.start_i && is_idle && !sel_ok);
        end
    end

    // Next-state logic; flush is handled in the register above.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_accept) state_d = PRIME;
            PRIME:   state_d = STREAM;
            STREAM:  if (&exhausted) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign base[c] = AW'(base_addr(32'(bus.tile_sel_i), c, K_DEPTH, N_CH));

        feeder_channel_ctrl #(
            .K_DEPTH    (K_DEPTH),
            .PT_DELAY   (PT_DELAY),
            .AW         (AW),
            .RESET_BASE (AW'(base_addr(0, c, K_DEPTH, N_CH)))
        ) u_ch (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .flush_i     (bus.flush_i),
            .load_i      (start_accept),
            .base_i      (base[c]),
            .prime_i     (state_q == PRIME),
            .stream_i    (state_q == STREAM),
            .pt_i        (bus.passthrough_valid_i[c]),
            .addr_o      (addr[c]),
            .adv_o       (adv[c]),
            .exhausted_o (exhausted[c]),
            .last_o      (bus.last_o[c])
        );

`ifdef FEEDER_ZERO_PAD_EN
        assign bus.data_o[c] = (exhausted[c] || is_idle) ? '0 : mem[addr[c]];
`else
        assign bus.data_o[c] = mem[addr[c]];
`endif
    end

    assign bus.wr_err_o      = err_q;
    assign bus.data_valid_o  = dv_q;
    assign bus.busy_o        = (state_q == PRIME) || (state_q == STREAM);
    assign bus.done_o        = (state_q == DONE) && !bus.flush_i;
    assign bus.queue_empty_o = is_idle;

endmodule

// File: tb/tb_row_tile_feeder.sv
// ============================================================================
// tb_row_tile_feeder
// Directed bench for row_tile_feeder. dut_a: N_CH=4, K_DEPTH=4, TILES=2,
// PT_DELAY=2, buffer word = its address. dut_b: N_CH=4, K_DEPTH=1, TILES=3,
// PT_DELAY=1, 16-bit words = 100 + address.
// ============================================================================
module tb_row_tile_feeder;

`ifdef FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    row_tile_feeder_if #(.N_CH(4), .K_DEPTH(4), .TILES(2), .DATA_WIDTH(32)) bus_a ();
    row_tile_feeder_if #(.N_CH(4), .K_DEPTH(1), .TILES(3), .DATA_WIDTH(16)) bus_b ();

    row_tile_feeder #(
        .N_CH(4), .K_DEPTH(4), .TILES(2), .DATA_WIDTH(32), .PT_DELAY(2)
    ) dut_a (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_a)
    );

    row_tile_feeder #(
        .N_CH(4), .K_DEPTH(1), .TILES(3), .DATA_WIDTH(16), .PT_DELAY(1)
    ) dut_b (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic start, input logic sel, input logic [3:0] pt);
        bus_a.start_i             = start;
        bus_a.tile_sel_i          = sel;
        bus_a.passthrough_valid_i = pt;
    endtask

    // Element value seen on data_o: blanked when the channel is exhausted or
    // idle in the zero-pad build.
    function automatic logic [63:0] shown(input logic [63:0] v, input bit blank);
        return (ZERO_PAD && blank) ? 64'd0 : v;
    endfunction

    // Full tile-0 stream on dut_a with every channel pulsed each cycle.
    // Caller has just driven start/tile 0/pt=1111 at a negedge.
    task automatic runTile0Stream(input string tag);
        int busy_e  [7] = '{1, 1, 1, 1, 1, 0, 0};
        int dv_e    [7] = '{0, 1, 1, 1, 1, 0, 0};
        int last_e  [7] = '{0, 0, 0, 0, 15, 0, 0};
        int done_e  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int data_e  [7] = '{8, 8, 9, 10, 11, 11, 11};
        bit blank_e [7] = '{0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                bus_a.start_i = 1'b0;
                checkOutput({tag, " prime data0 buffer intact"}, 64'(bus_a.data_o[0]), 64'd0);
                checkOutput({tag, " prime queue_empty"}, 64'(bus_a.queue_empty_o), 64'd0);
            end
            checkOutput($sformatf("%s c%0d busy", tag, i + 1), 64'(bus_a.busy_o), 64'(busy_e[i]));
            checkOutput($sformatf("%s c%0d data_valid", tag, i + 1), 64'(bus_a.data_valid_o), 64'(dv_e[i]));
            checkOutput($sformatf("%s c%0d last", tag, i + 1), 64'(bus_a.last_o), 64'(last_e[i]));
            checkOutput($sformatf("%s c%0d done", tag, i + 1), 64'(bus_a.done_o), 64'(done_e[i]));
            checkOutput($sformatf("%s c%0d data2", tag, i + 1), 64'(bus_a.data_o[2]),
                        shown(64'(data_e[i]), blank_e[i]));
        end
        checkOutput({tag, " end queue_empty"}, 64'(bus_a.queue_empty_o), 64'd1);
        bus_a.passthrough_valid_i = 4'b0000;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int last3_cnt;
        int done_cnt;
        logic [63:0] exp_d0;

        rstn = 1'b0;
        bus_a.wr_en_i = 1'b0; bus_a.wr_addr_i = '0; bus_a.wr_data_i = '0;
        bus_a.start_i = 1'b0; bus_a.tile_sel_i = '0; bus_a.flush_i = 1'b0;
        bus_a.passthrough_valid_i = '0;
        bus_b.wr_en_i = 1'b0; bus_b.wr_addr_i = '0; bus_b.wr_data_i = '0;
        bus_b.start_i = 1'b0; bus_b.tile_sel_i = '0; bus_b.flush_i = 1'b0;
        bus_b.passthrough_valid_i = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("reset busy", 64'(bus_a.busy_o), 64'd0);
        checkOutput("reset queue_empty", 64'(bus_a.queue_empty_o), 64'd1);
        checkOutput("reset done", 64'(bus_a.done_o), 64'd0);
        checkOutput("reset data_valid", 64'(bus_a.data_valid_o), 64'd0);
        checkOutput("reset last", 64'(bus_a.last_o), 64'd0);
        checkOutput("reset wr_err", 64'(bus_a.wr_err_o), 64'd0);
        checkOutput("reset b queue_empty", 64'(bus_b.queue_empty_o), 64'd1);
        rstn = 1'b1;
        tick();

        // Load both buffers
        for (int a = 0; a < 32; a++) begin
            bus_a.wr_en_i = 1'b1; bus_a.wr_addr_i = 5'(a); bus_a.wr_data_i = 32'(a);
            if (a < 12) begin
                bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 4'(a); bus_b.wr_data_i = 16'(100 + a);
            end else begin
                bus_b.wr_en_i = 1'b0;
            end
            tick();
        end
        bus_a.wr_en_i = 1'b0;
        bus_b.wr_en_i = 1'b0;
        checkOutput("load wr_err", 64'(bus_a.wr_err_o), 64'd0);
        tick();
        checkOutput("idle data2", 64'(bus_a.data_o[2]), shown(64'd8, 1'b1));

        // Tile 0, all channels pulsed every cycle
        applyStimulus(1'b1, 1'b0, 4'b1111);
        runTile0Stream("t0");

        // Tile 1, only channel 0 pulsed at cycles 5, 9, 13
        applyStimulus(1'b1, 1'b1, 4'b0000);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            if (cyc == 1) bus_a.start_i = 1'b0;
            if (cyc < 8)       exp_d0 = 64'd16;
            else if (cyc < 12) exp_d0 = 64'd17;
            else if (cyc < 16) exp_d0 = 64'd18;
            else               exp_d0 = shown(64'd19, 1'b1);
            checkOutput($sformatf("t1 c%0d data0", cyc), 64'(bus_a.data_o[0]), exp_d0);
            checkOutput($sformatf("t1 c%0d data_valid", cyc), 64'(bus_a.data_valid_o),
                        64'(cyc == 2 || cyc == 8 || cyc == 12 || cyc == 16));
            checkOutput($sformatf("t1 c%0d last", cyc), 64'(bus_a.last_o),
                        (cyc == 16) ? 64'd1 : 64'd0);
            checkOutput($sformatf("t1 c%0d done", cyc), 64'(bus_a.done_o), 64'd0);
            bus_a.passthrough_valid_i[0] = (cyc == 5 || cyc == 9 || cyc == 13);
        end
        checkOutput("t1 data1", 64'(bus_a.data_o[1]), 64'd20);
        checkOutput("t1 data2", 64'(bus_a.data_o[2]), 64'd24);
        checkOutput("t1 data3", 64'(bus_a.data_o[3]), 64'd28);
        checkOutput("t1 busy", 64'(bus_a.busy_o), 64'd1);

        // Channel 3 keeps getting pulses past exhaustion
        last3_cnt = 0;
        bus_a.passthrough_valid_i = 4'b1000;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_a.last_o[3]) last3_cnt++;
        end
        checkOutput("ch3 held at end", 64'(bus_a.data_o[3]), shown(64'd31, 1'b1));
        checkOutput("ch0 held at end", 64'(bus_a.data_o[0]), shown(64'd19, 1'b1));
        checkOutput("ch3 still busy", 64'(bus_a.busy_o), 64'd1);

        // Write while streaming is rejected
        bus_a.wr_en_i = 1'b1; bus_a.wr_addr_i = 5'd0; bus_a.wr_data_i = 32'hDEADBEEF;
        tick();
        bus_a.wr_en_i = 1'b0;
        checkOutput("stream write wr_err", 64'(bus_a.wr_err_o), 64'd1);
        tick();
        checkOutput("stream write wr_err clears", 64'(bus_a.wr_err_o), 64'd0);

        // Finish channels 1 and 2
        done_cnt = 0;
        bus_a.passthrough_valid_i = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_a.done_o) done_cnt++;
            if (bus_a.last_o[3]) last3_cnt++;
        end
        checkOutput("t1 done count", 64'(done_cnt), 64'd1);
        checkOutput("ch3 last count", 64'(last3_cnt), 64'd1);
        checkOutput("t1 queue_empty", 64'(bus_a.queue_empty_o), 64'd1);
        bus_a.passthrough_valid_i = 4'b0000;
        repeat (3) tick();

        // Out-of-range tile select on dut_b (TILES=3)
        bus_b.start_i = 1'b1; bus_b.tile_sel_i = 2'd3;
        tick();
        bus_b.start_i = 1'b0;
        checkOutput("bad tile wr_err", 64'(bus_b.wr_err_o), 64'd1);
        checkOutput("bad tile busy", 64'(bus_b.busy_o), 64'd0);
        tick();
        checkOutput("bad tile wr_err clears", 64'(bus_b.wr_err_o), 64'd0);
        checkOutput("bad tile queue_empty", 64'(bus_b.queue_empty_o), 64'd1);

        // Flush mid-stream, then restart tile 0
        applyStimulus(1'b1, 1'b0, 4'b1111);
        tick();
        bus_a.start_i = 1'b0;
        tick();
        tick();
        checkOutput("pre-flush data2", 64'(bus_a.data_o[2]), 64'd9);
        bus_a.flush_i = 1'b1;
        checkOutput("flush cycle done", 64'(bus_a.done_o), 64'd0);
        tick();
        checkOutput("flush busy", 64'(bus_a.busy_o), 64'd0);
        checkOutput("flush queue_empty", 64'(bus_a.queue_empty_o), 64'd1);
        checkOutput("flush data_valid", 64'(bus_a.data_valid_o), 64'd0);
        checkOutput("flush last", 64'(bus_a.last_o), 64'd0);
        checkOutput("flush done", 64'(bus_a.done_o), 64'd0);
        checkOutput("flush data2 base", 64'(bus_a.data_o[2]), shown(64'd8, 1'b1));
        bus_a.flush_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'b1111);
        runTile0Stream("restart");

        // K_DEPTH=1 on dut_b, tile 1
        bus_b.start_i = 1'b1; bus_b.tile_sel_i = 2'd1;
        tick();
        bus_b.start_i = 1'b0;
        checkOutput("k1 prime busy", 64'(bus_b.busy_o), 64'd1);
        checkOutput("k1 prime last", 64'(bus_b.last_o), 64'd0);
        checkOutput("k1 prime data2", 64'(bus_b.data_o[2]), 64'd106);
        tick();
        checkOutput("k1 last", 64'(bus_b.last_o), 64'hF);
        checkOutput("k1 data_valid", 64'(bus_b.data_valid_o), 64'd1);
        checkOutput("k1 stream done", 64'(bus_b.done_o), 64'd0);
        checkOutput("k1 exhausted data2", 64'(bus_b.data_o[2]), shown(64'd106, 1'b1));
        tick();
        checkOutput("k1 done", 64'(bus_b.done_o), 64'd1);
        checkOutput("k1 done last", 64'(bus_b.last_o), 64'd0);
        checkOutput("k1 done data_valid", 64'(bus_b.data_valid_o), 64'd0);
        tick();
        checkOutput("k1 idle done", 64'(bus_b.done_o), 64'd0);
        checkOutput("k1 idle queue_empty", 64'(bus_b.queue_empty_o), 64'd1);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        bus_a.start_i = 1'b0;
        tick();
        checkOutput("pre-reset data_valid", 64'(bus_a.data_valid_o), 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("async reset busy", 64'(bus_a.busy_o), 64'd0);
        checkOutput("async reset queue_empty", 64'(bus_a.queue_empty_o), 64'd1);
        checkOutput("async reset data_valid", 64'(bus_a.data_valid_o), 64'd0);
        checkOutput("async reset data3 base", 64'(bus_a.data_o[3]), shown(64'd12, 1'b1));
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("post-reset done", 64'(bus_a.done_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
